// File: rtl/alu_cmd_sequencer.sv
// Command front-end for the 16-bit ALU: buffers {opcode, A, B} words in a FIFO, issues legal
// opcodes to the ALU, filters NOP/RST/illegal locally and returns results on valid/ready.
module alu_cmd_sequencer #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned ALU_LAT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [35:0] cmd_data_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  output logic [15:0] alu_a_o,
  output logic [15:0] alu_b_o,
  output logic [3:0]  alu_opcode_o,
  input  logic [15:0] alu_result_i,
  output logic [15:0] res_data_o,
  output logic [3:0]  res_op_o,
  output logic        res_err_o,
  output logic        res_valid_o,
  input  logic        res_ready_i,
  output logic [7:0]  err_count_o
);

  localparam int unsigned PtrW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW  = $clog2(DEPTH + 1);
  localparam int unsigned WaitW = (ALU_LAT > 0) ? $clog2(ALU_LAT + 1) : 1;

  typedef enum logic [1:0] {StIdle, StExec, StOut} state_e;

  logic [35:0]      mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q, count_d;
  state_e           state_q, state_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic [15:0]      alu_a_q, alu_a_d, alu_b_q, alu_b_d, res_data_q, res_data_d;
  logic [3:0]       alu_op_q, alu_op_d, res_op_q, res_op_d;
  logic             res_err_q, res_err_d;
  logic [7:0]       err_cnt_q, err_cnt_d;
  logic             push, pop;
  logic [35:0]      head;

  assign cmd_ready_o = (count_q < CntW'(DEPTH));
  assign push        = cmd_valid_i && cmd_ready_o;
  assign head        = mem_q[rd_ptr_q];
  assign count_d     = count_q + CntW'(push) - CntW'(pop);

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_op_d   = alu_op_q;
    res_data_d = res_data_q;
    res_op_d   = res_op_q;
    res_err_d  = res_err_q;
    err_cnt_d  = err_cnt_q;
    pop        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (count_q != '0) begin
          pop = 1'b1;
          case (head[35:32])
            4'b0000: ; // NOP: dropped without a result
            4'b0001: begin
              res_data_d = '0;
              res_op_d   = 4'b0001;
              res_err_d  = 1'b0;
              err_cnt_d  = '0;
              state_d    = StOut;
            end
            4'b0100, 4'b0101, 4'b1000, 4'b1001,
            4'b1010, 4'b1011, 4'b1100, 4'b1101: begin
              alu_a_d  = head[31:16];
              alu_b_d  = head[15:0];
              alu_op_d = head[35:32];
              wait_d   = WaitW'(ALU_LAT);
              state_d  = StExec;
            end
            default: begin
              res_data_d = '0;
              res_op_d   = head[35:32];
              res_err_d  = 1'b1;
              if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
              state_d    = StOut;
            end
          endcase
        end
      end
      StExec: begin
        if (wait_q != '0) begin
          wait_d = wait_q - WaitW'(1);
        end else begin
          res_data_d = alu_result_i;
          res_op_d   = alu_op_q;
          res_err_d  = 1'b0;
          state_d    = StOut;
        end
      end
      StOut: begin
        if (res_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= cmd_data_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= StIdle;
      wait_q     <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= 4'b0000;
      res_data_q <= '0;
      res_op_q   <= 4'b0000;
      res_err_q  <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q    <= count_d;
      state_q    <= state_d;
      wait_q     <= wait_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_op_q   <= alu_op_d;
      res_data_q <= res_data_d;
      res_op_q   <= res_op_d;
      res_err_q  <= res_err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign alu_a_o      = alu_a_q;
  assign alu_b_o      = alu_b_q;
  assign alu_opcode_o = alu_op_q;
  assign res_data_o   = res_data_q;
  assign res_op_o     = res_op_q;
  assign res_err_o    = res_err_q;
  assign res_valid_o  = (state_q == StOut);
  assign err_count_o  = err_cnt_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench: a combinational-ALU instance for the vector table and backpressure,
// and an ALU_LAT=2 instance driven by a two-stage registered ALU stub.
module tb_alu_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [35:0] cmd_data;
  logic        cv0, cr0, cv2, cr2, rr0, rr2;
  logic [15:0] a0, b0, a2, b2, ar0, ar2, rd0, rd2, s1, s2;
  logic [3:0]  op0, op2, ro0, ro2;
  logic        re0, re2, rv0, rv2;
  logic [7:0]  ec0, ec2;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  function automatic logic [15:0] alu_f(input logic [3:0] op, input logic [15:0] a,
                                        input logic [15:0] b);
    case (op)
      4'b0100: return a + b;
      4'b0101: return a - b;
      4'b1000: return a & b;
      4'b1001: return a | b;
      4'b1010: return a ^ b;
      4'b1011: return ~(a & b);
      4'b1100: return ~(a | b);
      4'b1101: return ~a;
      default: return 16'h0000;
    endcase
  endfunction

  always_comb ar0 = alu_f(op0, a0, b0);

  // Registered ALU stub: result appears two edges after the operands settle.
  always_ff @(posedge clk) begin
    s1 <= alu_f(op2, a2, b2);
    s2 <= s1;
  end
  assign ar2 = s2;

  alu_cmd_sequencer #(.DEPTH(4), .ALU_LAT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .cmd_data_i(cmd_data), .cmd_valid_i(cv0), .cmd_ready_o(cr0),
    .alu_a_o(a0), .alu_b_o(b0), .alu_opcode_o(op0), .alu_result_i(ar0),
    .res_data_o(rd0), .res_op_o(ro0), .res_err_o(re0), .res_valid_o(rv0),
    .res_ready_i(rr0), .err_count_o(ec0)
  );

  alu_cmd_sequencer #(.DEPTH(4), .ALU_LAT(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .cmd_data_i(cmd_data), .cmd_valid_i(cv2), .cmd_ready_o(cr2),
    .alu_a_o(a2), .alu_b_o(b2), .alu_opcode_o(op2), .alu_result_i(ar2),
    .res_data_o(rd2), .res_op_o(ro2), .res_err_o(re2), .res_valid_o(rv2),
    .res_ready_i(rr2), .err_count_o(ec2)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [35:0] cmd;
    logic        has_res;
    logic [15:0] data;
    logic [3:0]  op;
    logic        err;
    logic [7:0]  ecnt;
    int          lat;
  } vec_t;

  vec_t vecs[15];

  initial begin
    int lat;
    int acc;
    logic saw;

    vecs[0]  = '{36'h4_0003_0005, 1'b1, 16'h0008, 4'h4, 1'b0, 8'd0, 2};
    vecs[1]  = '{36'h5_0010_0001, 1'b1, 16'h000F, 4'h5, 1'b0, 8'd0, 2};
    vecs[2]  = '{36'h8_F0F0_FF00, 1'b1, 16'hF000, 4'h8, 1'b0, 8'd0, 2};
    vecs[3]  = '{36'h9_F0F0_0F0F, 1'b1, 16'hFFFF, 4'h9, 1'b0, 8'd0, 2};
    vecs[4]  = '{36'hA_00FF_0F0F, 1'b1, 16'h0FF0, 4'hA, 1'b0, 8'd0, 2};
    vecs[5]  = '{36'hB_FFFF_00FF, 1'b1, 16'hFF00, 4'hB, 1'b0, 8'd0, 2};
    vecs[6]  = '{36'hC_00F0_0F00, 1'b1, 16'hF00F, 4'hC, 1'b0, 8'd0, 2};
    vecs[7]  = '{36'hD_1234_0000, 1'b1, 16'hEDCB, 4'hD, 1'b0, 8'd0, 2};
    vecs[8]  = '{36'h0_0000_0000, 1'b0, 16'h0000, 4'h0, 1'b0, 8'd0, 0};
    vecs[9]  = '{36'hE_1234_5678, 1'b1, 16'h0000, 4'hE, 1'b1, 8'd1, 1};
    vecs[10] = '{36'h2_0001_0001, 1'b1, 16'h0000, 4'h2, 1'b1, 8'd2, 1};
    vecs[11] = '{36'hF_AAAA_5555, 1'b1, 16'h0000, 4'hF, 1'b1, 8'd3, 1};
    vecs[12] = '{36'h1_FFFF_FFFF, 1'b1, 16'h0000, 4'h1, 1'b0, 8'd0, 1};
    vecs[13] = '{36'h4_FFFF_0001, 1'b1, 16'h0000, 4'h4, 1'b0, 8'd0, 2};
    vecs[14] = '{36'h5_0000_0001, 1'b1, 16'hFFFF, 4'h5, 1'b0, 8'd0, 2};

    rst_n = 1'b0; cv0 = 1'b0; cv2 = 1'b0; rr0 = 1'b0; rr2 = 1'b0; cmd_data = '0;
    tick; tick;
    chk("rst_res_valid", rv0, 0);
    chk("rst_cmd_ready", cr0, 1);
    chk("rst_alu_a", a0, 0);
    chk("rst_alu_op", op0, 0);
    chk("rst_res_data", rd0, 0);
    chk("rst_res_err", re0, 0);
    chk("rst_err_count", ec0, 0);
    chk("rst2_res_valid", rv2, 0);
    rst_n = 1'b1;
    tick;

    // Single ADD with exact latency
    cmd_data = 36'h4_0003_0005; cv0 = 1'b1;
    tick; cv0 = 1'b0;
    chk("add_e0_valid", rv0, 0);
    tick;
    chk("add_e1_alu_a", a0, 16'h0003);
    chk("add_e1_alu_b", b0, 16'h0005);
    chk("add_e1_alu_op", op0, 4'h4);
    chk("add_e1_valid", rv0, 0);
    tick;
    chk("add_e2_valid", rv0, 1);
    chk("add_e2_data", rd0, 16'h0008);
    chk("add_e2_op", ro0, 4'h4);
    rr0 = 1'b1; tick; rr0 = 1'b0;
    chk("add_done_valid", rv0, 0);

    // Vector table, one command at a time
    foreach (vecs[i]) begin
      cmd_data = vecs[i].cmd; cv0 = 1'b1;
      tick; cv0 = 1'b0;
      if (vecs[i].has_res) begin
        lat = 0;
        while (!rv0 && lat < 10) begin tick; lat++; end
        chk($sformatf("vec%0d_valid", i), rv0, 1);
        chk($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
        chk($sformatf("vec%0d_data", i), rd0, vecs[i].data);
        chk($sformatf("vec%0d_op", i), ro0, vecs[i].op);
        chk($sformatf("vec%0d_err", i), re0, vecs[i].err);
        chk($sformatf("vec%0d_ecnt", i), ec0, vecs[i].ecnt);
        rr0 = 1'b1; tick; rr0 = 1'b0;
      end else begin
        saw = 1'b0;
        for (int k = 0; k < 4; k++) begin tick; saw |= rv0; end
        chk($sformatf("vec%0d_no_result", i), saw, 0);
      end
    end

    // Backpressure: 1 in flight, 4 buffered, 6th refused
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      cmd_data = {4'h5, 16'(16'h0010 + i), 16'h0001}; cv0 = 1'b1;
      if (cr0) acc++;
      tick;
    end
    cv0 = 1'b0;
    chk("bp_accepted", acc, 5);
    chk("bp_full_ready", cr0, 0);
    chk("bp_stalled_valid", rv0, 1);
    rr0 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      lat = 0;
      while (!rv0 && lat < 8) begin tick; lat++; end
      chk($sformatf("bp%0d_valid", k), rv0, 1);
      chk($sformatf("bp%0d_data", k), rd0, 16'(16'h000F + k));
      tick;
    end
    saw = 1'b0;
    for (int k = 0; k < 6; k++) begin tick; saw |= rv0; end
    chk("bp_no_extra", saw, 0);
    chk("bp_ready_again", cr0, 1);
    rr0 = 1'b0;

    // ALU_LAT=2: valid exactly 4 edges after accept
    cmd_data = 36'hC_00F0_0F00; cv2 = 1'b1;
    tick; cv2 = 1'b0;
    lat = 0;
    while (!rv2 && lat < 12) begin tick; lat++; end
    chk("lat2_lat", lat, 4);
    chk("lat2_data", rd2, 16'hF00F);
    chk("lat2_op", ro2, 4'hC);
    rr2 = 1'b1; tick; rr2 = 1'b0;

    cmd_data = 36'hE_0000_0000; cv2 = 1'b1;
    tick; cv2 = 1'b0; tick;
    chk("lat2_ill_ecnt", ec2, 1);
    rr2 = 1'b1; tick; rr2 = 1'b0;

    // Reset while in EXEC with 3 entries queued
    for (int i = 0; i < 4; i++) begin
      cmd_data = {4'h4, 16'(i + 1), 16'h0001}; cv2 = 1'b1;
      tick;
    end
    cv2 = 1'b0;
    chk("midrst_pre_op", op2, 4'h4);
    chk("midrst_pre_valid", rv2, 0);
    rst_n = 1'b0; tick; rst_n = 1'b1;
    chk("midrst_valid", rv2, 0);
    chk("midrst_ready", cr2, 1);
    chk("midrst_ecnt", ec2, 0);
    chk("midrst_alu_op", op2, 0);
    chk("midrst_alu_a", a2, 0);
    rr2 = 1'b1;
    saw = 1'b0;
    for (int k = 0; k < 10; k++) begin tick; saw |= rv2; end
    chk("midrst_fifo_empty", saw, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
